uaf_cfg_spi: RTL and testbench
==============================

UAF_CFG_SPI -- requirements
Module: uaf_cfg_spi

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, synchronizer depth on SPI inputs (>=2).
REQ-002 SHALL have parameter ID_VALUE, default 8'hA5, read-only identification byte at address 3.
REQ-003 clk  input  1  system clock; must be >= 8x spi_sclk frequency.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 spi_sclk  input  1  SPI clock, mode 0 (CPOL=0, CPHA=0), asynchronous to clk.
REQ-006 spi_cs_n  input  1  SPI chip select, active-low, asynchronous.
REQ-007 spi_mosi  input  1  SPI serial data in, MSB first, asynchronous.
REQ-008 spi_miso  output  1  SPI serial data out, MSB first.
REQ-009 cfg_en  output  1  filter enable.
REQ-010 cfg_mode  output  2  filter response select: 00 LP, 01 HP, 10 BP, 11 notch.
REQ-011 cfg_tune  output  6  cutoff tuning code.
REQ-012 cfg_gain  output  4  gain code.
REQ-013 cfg_update  output  1  one-cycle pulse when any cfg_* output changes.
REQ-014 err_frame  output  1  one-cycle pulse on a rejected frame.

Function
REQ-015 spi_sclk, spi_cs_n, spi_mosi SHALL each pass a SYNC_STAGES flop synchronizer; all edge detection uses synchronized values.
REQ-016 Frame: 16 bits; bit15 W (1 = write, 0 = read), bits14:12 address, bits11:8 ignored, bits7:0 write data.
REQ-017 MOSI SHALL be sampled on each synchronized sclk rising edge while cs_n low.
REQ-018 FSM states IDLE, CMD, DATA, HOLD: IDLE->CMD on cs_n fall; CMD->DATA after 8th rising edge; DATA->HOLD after 16th; any state->IDLE on cs_n rise.
REQ-019 Register map: 0 CTRL {bit2 en, bits1:0 mode}; 1 TUNE bits5:0; 2 GAIN bits3:0; 3 ID (read-only, ID_VALUE); 4-7 unmapped.
REQ-020 Write data SHALL be held in a shadow register and committed only on cs_n rise from HOLD with exactly 16 rising edges counted.
REQ-021 Commit: target cfg_* outputs and cfg_update SHALL change in the clk cycle after the synchronized cs_n rise is detected.
REQ-022 cfg_update SHALL NOT pulse if the committed value equals the current value.
REQ-023 Read: on entering DATA, the addressed register (zero-extended to 8 bits; unmapped = 8'h00) SHALL load into a TX shift register.
REQ-024 spi_miso SHALL present TX bit7 on entering DATA and shift to the next bit on each synchronized sclk falling edge during DATA; spi_miso = 0 in IDLE, CMD and HOLD.
REQ-025 err_frame SHALL pulse on cs_n rise when the rising-edge count != 16, or a write targets address 3-7; no register changes in either case.
REQ-026 Rising edges counted in HOLD (17th and later) SHALL make the frame invalid (count != 16).
REQ-027 If a synchronized sclk edge and cs_n rise are detected in the same cycle, cs_n rise SHALL take priority and the edge SHALL be ignored.
REQ-028 A cs_n fall with no sclk edges followed by cs_n rise SHALL produce err_frame and no commit.
REQ-029 Bit counter SHALL saturate at 31; it SHALL NOT wrap.

Reset
REQ-030 While rst high: FSM IDLE, bit counter 0, shift registers 0, synchronizers loaded with idle levels (sclk 0, cs_n 1, mosi 0).
REQ-031 Reset outputs: cfg_en 0, cfg_mode 00, cfg_tune 6'h20, cfg_gain 4'h4, spi_miso 0, cfg_update 0, err_frame 0.
REQ-032 Reset mid-frame SHALL discard the shadow register; a frame in progress when rst deasserts SHALL be ignored until the next cs_n fall.

Structure
REQ-033 Package uaf_pkg SHALL hold: FSM state enum, register address constants, cfg reset values, mode encodings.
REQ-034 One sub-module uaf_sync (parameterized-depth single-bit synchronizer with reset value parameter), instantiated three times.

Verification
REQ-035 After reset: cfg_en=0, cfg_mode=00, cfg_tune=0x20, cfg_gain=0x4, no pulses.
REQ-036 Write 16'h9015 (write, addr 1, data 0x15) -> cfg_tune=0x15 and one cfg_update pulse, one cycle after the synchronized cs_n rise.
REQ-037 Read 16'h3000 (read, addr 3) -> spi_miso bits during DATA = 1010_0101 (0xA5); cfg outputs unchanged.
REQ-038 Write 16'h8007 with 17 sclk edges -> err_frame pulse, cfg_* unchanged; write 16'hB0FF (addr 3) -> err_frame pulse.
REQ-039 Write 16'h8005 (CTRL: en=1, mode=01) with cs_n released after 9 edges, then rst asserted mid-way through a second identical frame -> no commit on either frame, all outputs at reset values.
REQ-040 Rewrite of current value (16'hA004 when gain=0x4) -> no cfg_update, no err_frame.

Source files
------------

// File: rtl/uaf_pkg.sv
// Shared types and constants for the filter configuration SPI slave.
package uaf_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CMD,
    ST_DATA,
    ST_HOLD
  } state_t;

  localparam logic [2:0] ADDR_CTRL = 3'd0;
  localparam logic [2:0] ADDR_TUNE = 3'd1;
  localparam logic [2:0] ADDR_GAIN = 3'd2;
  localparam logic [2:0] ADDR_ID   = 3'd3;

  localparam logic [1:0] MODE_LP    = 2'b00;
  localparam logic [1:0] MODE_HP    = 2'b01;
  localparam logic [1:0] MODE_BP    = 2'b10;
  localparam logic [1:0] MODE_NOTCH = 2'b11;

  localparam logic       CFG_EN_RST   = 1'b0;
  localparam logic [1:0] CFG_MODE_RST = MODE_LP;
  localparam logic [5:0] CFG_TUNE_RST = 6'h20;
  localparam logic [3:0] CFG_GAIN_RST = 4'h4;

  localparam logic [4:0] BIT_CNT_MAX = 5'd31;

endpackage

// File: rtl/uaf_sync.sv
// Single-bit multi-flop synchronizer with a selectable reset level.
module uaf_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk) begin
    if (rst) ff <= {STAGES{RST_VAL}};
    else     ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/uaf_cfg_spi.sv
// SPI mode-0 slave exposing the filter configuration registers.
module uaf_cfg_spi
  import uaf_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] ID_VALUE    = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       spi_sclk,
  input  logic       spi_cs_n,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic       cfg_en,
  output logic [1:0] cfg_mode,
  output logic [5:0] cfg_tune,
  output logic [3:0] cfg_gain,
  output logic       cfg_update,
  output logic       err_frame
);

  localparam int SW = $clog2(SYNC_STAGES + 2);

  logic sclk_s, cs_n_s, mosi_s;
  logic sclk_q, cs_n_q;
  logic [SW-1:0] settle_cnt;
  logic settled;
  logic sclk_rise, sclk_fall, cs_rise, cs_fall, rise_ev, fall_ev;
  state_t state, state_nxt;
  logic in_frame;
  logic [4:0] bit_cnt;
  logic [15:0] rx_sr;
  logic [7:0] tx_sr;
  logic [7:0] rd_data;
  logic [2:0] cmd_addr, wr_addr;
  logic frame_ok, commit, frame_err;

  uaf_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst(rst), .d(spi_sclk), .q(sclk_s));
  uaf_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clk(clk), .rst(rst), .d(spi_cs_n), .q(cs_n_s));
  uaf_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst(rst), .d(spi_mosi), .q(mosi_s));

  // Events stay masked until the synchronizers have flushed their reset levels,
  // so a chip select already low at reset release never looks like a new frame.
  assign settled = (settle_cnt == SW'(SYNC_STAGES + 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      settle_cnt <= '0;
      sclk_q     <= 1'b0;
      cs_n_q     <= 1'b1;
    end else begin
      if (!settled) settle_cnt <= settle_cnt + 1'b1;
      sclk_q <= sclk_s;
      cs_n_q <= cs_n_s;
    end
  end

  assign sclk_rise = settled & sclk_s & ~sclk_q;
  assign sclk_fall = settled & ~sclk_s & sclk_q;
  assign cs_rise   = settled & cs_n_s & ~cs_n_q;
  assign cs_fall   = settled & ~cs_n_s & cs_n_q;
  assign rise_ev   = sclk_rise & ~cs_rise;
  assign fall_ev   = sclk_fall & ~cs_rise;
  assign in_frame  = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (cs_fall) state_nxt = ST_CMD;
      ST_CMD: begin
        if (cs_rise) state_nxt = ST_IDLE;
        else if (rise_ev && bit_cnt == 5'd7) state_nxt = ST_DATA;
      end
      ST_DATA: begin
        if (cs_rise) state_nxt = ST_IDLE;
        else if (rise_ev && bit_cnt == 5'd15) state_nxt = ST_HOLD;
      end
      ST_HOLD: if (cs_rise) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Address field of the command byte as it completes on the 8th rising edge.
  assign cmd_addr = rx_sr[5:3];

  always_comb begin
    rd_data = 8'h00;
    case (cmd_addr)
      ADDR_CTRL: rd_data = {5'b0, cfg_en, cfg_mode};
      ADDR_TUNE: rd_data = {2'b0, cfg_tune};
      ADDR_GAIN: rd_data = {4'b0, cfg_gain};
      ADDR_ID:   rd_data = ID_VALUE;
      default:   rd_data = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt <= '0;
      rx_sr   <= '0;
      tx_sr   <= '0;
    end else begin
      if (cs_fall) begin
        bit_cnt <= '0;
        rx_sr   <= '0;
      end else if (in_frame && rise_ev) begin
        if (bit_cnt != BIT_CNT_MAX) bit_cnt <= bit_cnt + 5'd1;
        if (state != ST_HOLD) rx_sr <= {rx_sr[14:0], mosi_s};
      end
      // The falling edge that closes the command byte keeps bit7 on the line
      // so the master samples it on the first data rising edge.
      if (state == ST_CMD && rise_ev && bit_cnt == 5'd7)
        tx_sr <= rd_data;
      else if (state == ST_DATA && fall_ev && bit_cnt > 5'd8)
        tx_sr <= {tx_sr[6:0], 1'b0};
    end
  end

  assign spi_miso = (state == ST_DATA) & tx_sr[7];

  assign wr_addr   = rx_sr[14:12];
  assign frame_ok  = (state == ST_HOLD) && (bit_cnt == 5'd16);
  assign commit    = in_frame & cs_rise & frame_ok & rx_sr[15] & (wr_addr <= ADDR_GAIN);
  assign frame_err = in_frame & cs_rise & (~frame_ok | (rx_sr[15] & (wr_addr > ADDR_GAIN)));

  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_en     <= CFG_EN_RST;
      cfg_mode   <= CFG_MODE_RST;
      cfg_tune   <= CFG_TUNE_RST;
      cfg_gain   <= CFG_GAIN_RST;
      cfg_update <= 1'b0;
      err_frame  <= 1'b0;
    end else begin
      cfg_update <= 1'b0;
      err_frame  <= frame_err;
      if (commit) begin
        case (wr_addr)
          ADDR_CTRL: begin
            {cfg_en, cfg_mode} <= rx_sr[2:0];
            cfg_update         <= ({cfg_en, cfg_mode} != rx_sr[2:0]);
          end
          ADDR_TUNE: begin
            cfg_tune   <= rx_sr[5:0];
            cfg_update <= (cfg_tune != rx_sr[5:0]);
          end
          ADDR_GAIN: begin
            cfg_gain   <= rx_sr[3:0];
            cfg_update <= (cfg_gain != rx_sr[3:0]);
          end
          default: cfg_update <= 1'b0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uaf_cfg_spi.sv
// Bench for uaf_cfg_spi: directed frames, then random frames against a register-map model.
module tb_uaf_cfg_spi;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       spi_sclk = 1'b0;
  logic       spi_cs_n = 1'b1;
  logic       spi_mosi = 1'b0;
  logic       spi_miso;
  logic       cfg_en;
  logic [1:0] cfg_mode;
  logic [5:0] cfg_tune;
  logic [3:0] cfg_gain;
  logic       cfg_update;
  logic       err_frame;

  localparam int H = 6;

  always #5 clk = ~clk;

  uaf_cfg_spi dut (
    .clk(clk), .rst(rst),
    .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso),
    .cfg_en(cfg_en), .cfg_mode(cfg_mode), .cfg_tune(cfg_tune), .cfg_gain(cfg_gain),
    .cfg_update(cfg_update), .err_frame(err_frame)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0, upd_cnt = 0, err_cnt = 0, upd_cyc = 0;
  int rise_cyc = 0;

  always @(posedge clk) begin
    #2;
    cyc++;
    if (cfg_update) begin
      upd_cnt++;
      upd_cyc = cyc;
    end
    if (err_frame) err_cnt++;
  end

  // Register model: value of each writable register, masked to its width.
  logic [7:0] m_reg [0:2];
  logic [7:0] m_mask [0:2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic half();
    repeat (H) @(negedge clk);
  endtask

  task automatic model_reset();
    m_reg[0] = 8'h00;
    m_reg[1] = 8'h20;
    m_reg[2] = 8'h04;
  endtask

  task automatic model_frame(input logic [15:0] w, input int n,
                             output logic exp_err, output logic exp_upd,
                             output logic [7:0] exp_rd);
    int a;
    logic [7:0] d;
    a = int'(w[14:12]);
    d = w[7:0];
    exp_err = 1'b0;
    exp_upd = 1'b0;
    exp_rd  = 8'h00;
    if (n != 16 || (w[15] && a >= 3)) begin
      exp_err = 1'b1;
    end else if (w[15]) begin
      exp_upd  = (m_reg[a] != (d & m_mask[a]));
      m_reg[a] = d & m_mask[a];
    end else begin
      if (a < 3)       exp_rd = m_reg[a];
      else if (a == 3) exp_rd = 8'hA5;
    end
  endtask

  task automatic check_cfg(input string tag);
    check({tag, ".en"},   32'(cfg_en),   32'(m_reg[0][2]));
    check({tag, ".mode"}, 32'(cfg_mode), 32'(m_reg[0][1:0]));
    check({tag, ".tune"}, 32'(cfg_tune), 32'(m_reg[1][5:0]));
    check({tag, ".gain"}, 32'(cfg_gain), 32'(m_reg[2][3:0]));
  endtask

  // Master side of one frame: n rising edges, MISO sampled just before rises 9..16.
  task automatic spi_frame(input logic [15:0] w, input int n, input int rst_at,
                           output logic [7:0] rd);
    rd = 8'h00;
    @(negedge clk);
    spi_cs_n = 1'b0;
    half();
    for (int i = 0; i < n; i++) begin
      spi_mosi = (i < 16) ? w[15-i] : 1'b0;
      if (i == rst_at) begin
        rst = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
      end
      half();
      if (i >= 8 && i < 16) rd[15-i] = spi_miso;
      spi_sclk = 1'b1;
      half();
      spi_sclk = 1'b0;
    end
    half();
    spi_cs_n = 1'b1;
    rise_cyc = cyc;
    repeat (12) @(negedge clk);
    spi_mosi = 1'b0;
  endtask

  task automatic do_frame(input logic [15:0] w, input int n, input string tag);
    int u0, e0;
    logic exp_err, exp_upd;
    logic [7:0] exp_rd, rd;
    u0 = upd_cnt;
    e0 = err_cnt;
    model_frame(w, n, exp_err, exp_upd, exp_rd);
    spi_frame(w, n, -1, rd);
    check({tag, ".err"}, 32'(err_cnt - e0), 32'(exp_err));
    check({tag, ".upd"}, 32'(upd_cnt - u0), 32'(exp_upd));
    check({tag, ".miso_idle"}, 32'(spi_miso), 32'd0);
    check_cfg(tag);
    if (!w[15] && n == 16) check({tag, ".rd"}, 32'(rd), 32'(exp_rd));
  endtask

  initial begin
    logic [7:0] rd;
    logic [15:0] w;
    int n, u0, e0;

    m_mask[0] = 8'h07;
    m_mask[1] = 8'h3F;
    m_mask[2] = 8'h0F;
    model_reset();

    // Reset state
    repeat (10) @(negedge clk);
    check("rst.miso", 32'(spi_miso), 32'd0);
    check_cfg("rst");
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check_cfg("post_rst");
    check("post_rst.upd", 32'(upd_cnt), 32'd0);
    check("post_rst.err", 32'(err_cnt), 32'd0);

    // Tune write and its commit latency
    do_frame(16'h9015, 16, "wr_tune");
    check("wr_tune.tune_val", 32'(cfg_tune), 32'h15);
    check("wr_tune.latency", 32'(upd_cyc - rise_cyc), 32'd3);

    // ID read
    do_frame(16'h3000, 16, "rd_id");

    // Bad frames
    do_frame(16'h8007, 17, "edges17");
    do_frame(16'hB0FF, 16, "wr_id");
    do_frame(16'h8005, 0, "no_edges");

    // Rewrite of the current gain
    do_frame(16'hA004, 16, "rewrite_gain");

    // Short frame, then reset in the middle of a full one
    do_frame(16'h8005, 9, "edges9");
    u0 = upd_cnt;
    e0 = err_cnt;
    spi_frame(16'h8005, 16, 10, rd);
    model_reset();
    check_cfg("mid_rst");
    check("mid_rst.upd", 32'(upd_cnt - u0), 32'd0);
    check("mid_rst.err", 32'(err_cnt - e0), 32'd0);
    check("mid_rst.miso", 32'(spi_miso), 32'd0);

    // The next full frame after reset is accepted again
    do_frame(16'h8005, 16, "after_rst");

    // Random frames
    for (int k = 0; k < 40; k++) begin
      w = 16'($urandom);
      w[14:12] = 3'($urandom_range(0, 4));
      w[15] = ($urandom_range(0, 3) != 0);
      n = ($urandom_range(0, 9) < 7) ? 16 : int'($urandom_range(0, 20));
      do_frame(w, n, $sformatf("rnd%0d", k));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
